// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the WB stage
// (primary, never back-pressured) and multi-cycle result sources (secondary,
// valid/ready). Secondary results queue in a small FIFO and drain on cycles
// the primary leaves free. A scoreboard lookup (busy1/busy2) lets ID stall on
// registers that still have a queued write.
//
// Optional feature macro: WBARB_STARVE_EN
//   When defined, a FIFO head that waits STARVE_MAX cycles raises stall_req
//   for one cycle, which forces that head onto the write port.
//   When undefined, stall_req is tied low and the FIFO drains only on cycles
//   without a primary write.
module wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  // primary writer (WB stage)
  input  logic                     p_we_i,
  input  logic [AW-1:0]            p_waddr_i,
  input  logic [DW-1:0]            p_wdata_i,
  // secondary writer (multi-cycle units)
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [AW-1:0]            s_waddr_i,
  input  logic [DW-1:0]            s_wdata_i,
  // scoreboard lookup from ID
  input  logic [AW-1:0]            raddr1_i,
  input  logic [AW-1:0]            raddr2_i,
  output logic                     busy1_o,
  output logic                     busy2_o,
  // register file write port
  output logic                     we_o,
  output logic [AW-1:0]            waddr_o,
  output logic [DW-1:0]            wdata_o,
  // pipeline control
  output logic                     stall_req_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  wr_req_t         mem_q [DEPTH];
  wr_req_t         head;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] hit1, hit2;

  logic            prim_v;
  logic            sel_s;
  logic            push;
  logic            pop;
  logic            stall_req_q;

  assign head   = mem_q[rd_ptr_q];
  assign prim_v = p_we_i & (p_waddr_i != '0);

  // Starvation guard: the head may be overtaken by the primary only so long.
`ifdef WBARB_STARVE_EN
  localparam int WW = $clog2(STARVE_MAX) + 1;

  logic [WW-1:0] wait_q, wait_d;
  logic          stall_req_d;

  // Count cycles the head is left waiting; arm a one-cycle stall at the limit.
  always_comb begin
    wait_d      = '0;
    stall_req_d = 1'b0;
    if ((cnt_q != '0) && !pop) begin
      wait_d      = wait_q + 1'b1;
      stall_req_d = (wait_q == WW'(STARVE_MAX - 1));
    end
  end

  // Wait counter and stall request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q      <= '0;
      stall_req_q <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      stall_req_q <= stall_req_d;
    end
  end
`else
  assign stall_req_q = 1'b0;
`endif

  // The FIFO wins the port when the primary is idle, or when a stall holds WB.
  // A stall is only ever raised with a non-empty FIFO, so the head is there.
  assign sel_s = (cnt_q != '0) & (~prim_v | stall_req_q);
  assign pop   = sel_s;

  // No bypass: a full FIFO refuses even if it pops this cycle.
  assign s_ready_o = rst_ni & (cnt_q < CW'(DEPTH));

  // Writes to r0 are accepted from the source but never queued.
  assign push = s_valid_i & s_ready_o & (s_waddr_i != '0);

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: s_waddr_i, data: s_wdata_i};
  end

  // Per-entry scoreboard compare. An entry is live when its distance from the
  // read pointer is below the occupancy; the popping head still counts.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_ptr_q;
    assign ent_vld[i] = ({1'b0, off} < cnt_q);
    assign hit1[i]    = ent_vld[i] & (mem_q[i].addr == raddr1_i);
    assign hit2[i]    = ent_vld[i] & (mem_q[i].addr == raddr2_i);
  end

  assign busy1_o = rst_ni & (raddr1_i != '0) & (|hit1);
  assign busy2_o = rst_ni & (raddr2_i != '0) & (|hit2);

  // Write port mux: FIFO head, then primary, else idle zeros.
  always_comb begin
    we_o    = 1'b0;
    waddr_o = '0;
    wdata_o = '0;
    if (rst_ni) begin
      if (sel_s) begin
        we_o    = 1'b1;
        waddr_o = head.addr;
        wdata_o = head.data;
      end else if (prim_v) begin
        we_o    = 1'b1;
        waddr_o = p_waddr_i;
        wdata_o = p_wdata_i;
      end
    end
  end

  assign stall_req_o = stall_req_q;
  assign count_o     = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_wb_port_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;
  localparam int AW         = 5;
  localparam int DW         = 32;

  logic          clk, rst_n;
  logic          p_we, s_valid, s_ready;
  logic [AW-1:0] p_waddr, s_waddr, raddr1, raddr2, waddr;
  logic [DW-1:0] p_wdata, s_wdata, wdata;
  logic          busy1, busy2, we, stall_req;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .p_we_i(p_we), .p_waddr_i(p_waddr), .p_wdata_i(p_wdata),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_waddr_i(s_waddr), .s_wdata_i(s_wdata),
    .raddr1_i(raddr1), .raddr2_i(raddr2), .busy1_o(busy1), .busy2_o(busy2),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
    .stall_req_o(stall_req), .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_we = 0; p_waddr = 0; p_wdata = 0;
    s_valid = 0; s_waddr = 0; s_wdata = 0;
    raddr1 = 0; raddr2 = 0;
  endtask

  // ---------------- reference model: queue of pending writes ----------------
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t mq[$];
  int   m_wait;
  bit   m_stall;

  // Compare on the falling edge (inputs stable since posedge+1), then commit
  // what the coming rising edge must do to the queue.
  initial begin
    int   sz;
    bit   pv, ss, rdy, nstall, e_we, e_b1, e_b2;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    ent_t e;
    m_wait = 0; m_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete(); m_wait = 0; m_stall = 0;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", {busy1, busy2}, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_stall", stall_req, 0);
      end else begin
        sz  = mq.size();
        pv  = p_we && (p_waddr != 0);
        ss  = (sz != 0) && (!pv || m_stall);
        rdy = sz < DEPTH;
        e_we = ss || pv;
        e_a  = ss ? mq[0].a : (pv ? p_waddr : '0);
        e_d  = ss ? mq[0].d : (pv ? p_wdata : '0);
        e_b1 = 0; e_b2 = 0;
        foreach (mq[i]) begin
          if (raddr1 != 0 && mq[i].a == raddr1) e_b1 = 1;
          if (raddr2 != 0 && mq[i].a == raddr2) e_b2 = 1;
        end
        chk("m_we", we, e_we);
        chk("m_waddr", waddr, e_a);
        chk("m_wdata", wdata, e_d);
        chk("m_busy1", busy1, e_b1);
        chk("m_busy2", busy2, e_b2);
        chk("m_ready", s_ready, rdy);
        chk("m_count", count, sz);
        chk("m_stall", stall_req, m_stall);
        nstall = 0;
`ifdef WBARB_STARVE_EN
        if (sz == 0 || ss) m_wait = 0;
        else begin
          nstall = (m_wait == STARVE_MAX - 1);
          m_wait++;
        end
`endif
        m_stall = nstall;
        if (ss) void'(mq.pop_front());
        if (s_valid && rdy && s_waddr != 0) begin
          e.a = s_waddr; e.d = s_wdata;
          mq.push_back(e);
        end
      end
    end
  end

  // ---------------- directed scenarios, then random traffic ----------------
  initial begin
    rst_n = 0; idle();
    tick(); tick();
    #3 chk("rst_s_ready", s_ready, 0);

    // reset in the middle of a stream
    tick(); rst_n = 1; p_we = 1; p_waddr = 5; p_wdata = 32'h55;
    s_valid = 1; s_waddr = 1; s_wdata = 32'h101;
    tick(); s_waddr = 2; s_wdata = 32'h102;
    tick(); s_valid = 0;
    #3 chk("t1_count2", count, 2);
    tick(); rst_n = 0;
    #3 chk("t1_count_rst", count, 0);
    chk("t1_we_rst", we, 0);
    tick(); rst_n = 1; idle();
    #3 chk("t1_ready", s_ready, 1);
    chk("t1_count", count, 0);

    // primary write, zero latency
    tick(); p_we = 1; p_waddr = 3; p_wdata = 32'hDEADBEEF;
    #3 chk("t2_we", we, 1);
    chk("t2_waddr", waddr, 3);
    chk("t2_wdata", wdata, 32'hDEADBEEF);

    // secondary write drains on an idle cycle
    tick(); idle(); s_valid = 1; s_waddr = 7; s_wdata = 32'h11;
    #3 chk("t3_count0", count, 0);
    tick(); s_valid = 0;
    #3 chk("t3_we", we, 1);
    chk("t3_waddr", waddr, 7);
    chk("t3_wdata", wdata, 32'h11);
    tick();
    #3 chk("t3_count_after", count, 0);

    // fill under a held primary, check full and scoreboard
    tick(); p_we = 1; p_waddr = 5; p_wdata = 32'h55;
    for (int a = 1; a <= 4; a++) begin
      s_valid = 1; s_waddr = AW'(a); s_wdata = 32'h100 + a;
      #3 chk("t4_ready_fill", s_ready, 1);
      tick();
    end
    s_waddr = 8; s_wdata = 32'h108; raddr1 = 2; raddr2 = 9;
    #3 chk("t4_count", count, 4);
    chk("t4_ready", s_ready, 0);
    chk("t4_busy1", busy1, 1);
    chk("t4_busy2", busy2, 0);
    chk("t4_waddr_prim", waddr, 5);
    tick(); s_valid = 0;
    #3 chk("t4_refused", count, 4);
    tick(); p_we = 0;
    for (int k = 1; k <= 4; k++) begin
      #3 chk("t4_order_addr", waddr, k);
      chk("t4_order_data", wdata, 32'h100 + k);
      tick();
    end
    #3 chk("t4_drained", count, 0);

    // r0 pushes are dropped; p_waddr=0 leaves the slot to the FIFO
    idle(); s_valid = 1; s_waddr = 0; s_wdata = 32'h77;
    tick(); s_valid = 0;
    #3 chk("t5_count", count, 0);
    chk("t5_we", we, 0);
    s_valid = 1; s_waddr = 6; s_wdata = 32'h66;
    tick(); s_valid = 0; p_we = 1; p_waddr = 0; p_wdata = 32'h123;
    #3 chk("t5_we_fifo", we, 1);
    chk("t5_waddr", waddr, 6);
    chk("t5_wdata", wdata, 32'h66);
    tick();
    #3 chk("t5_count_after", count, 0);
    chk("t5_we_idle", we, 0);

    // starvation under a held primary
    idle(); p_we = 1; p_waddr = 10; p_wdata = 32'hAAAA;
    s_valid = 1; s_waddr = 12; s_wdata = 32'hCC;
    tick(); s_valid = 0;
`ifdef WBARB_STARVE_EN
    for (int k = 0; k < 8; k++) begin
      #3 chk("t6_nostall", stall_req, 0);
      chk("t6_prim", waddr, 10);
      tick();
    end
    #3 chk("t6_stall", stall_req, 1);
    chk("t6_head_addr", waddr, 12);
    chk("t6_head_data", wdata, 32'hCC);
    tick();
    #3 chk("t6_stall_clr", stall_req, 0);
    chk("t6_prim_back", waddr, 10);
    chk("t6_count", count, 0);
`else
    for (int k = 0; k < 12; k++) begin
      #3 chk("t6_nostall", stall_req, 0);
      chk("t6_prim", waddr, 10);
      chk("t6_count", count, 1);
      tick();
    end
    p_we = 0;
    #3 chk("t6_head_addr", waddr, 12);
    tick();
    #3 chk("t6_count_after", count, 0);
`endif

    // randomized traffic; heavy-primary phases exercise starvation
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n   = ($urandom_range(0, 599) != 0);
      p_we    = ((c / 150) % 2 == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 1) == 1);
      p_waddr = AW'($urandom_range(0, 7));
      p_wdata = $urandom;
      s_valid = ($urandom_range(0, 1) == 1);
      s_waddr = AW'($urandom_range(0, 7));
      s_wdata = $urandom;
      raddr1  = AW'($urandom_range(0, 7));
      raddr2  = AW'($urandom_range(0, 7));
    end
    tick(); rst_n = 1; idle();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
